// File: rtl/mc_control_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// The controller side is master; the datapath side is slave.
interface mc_control_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  modport master (
    input  op, funct, zero,
    output pcen, memwrite, irwrite, regwrite,
    output iord, memtoreg, regdst, alusrca,
    output alusrcb, pcsrc, alucontrol, state
  );

  modport slave (
    output op, funct, zero,
    input  pcen, memwrite, irwrite, regwrite,
    input  iord, memtoreg, regdst, alusrca,
    input  alusrcb, pcsrc, alucontrol, state
  );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle MIPS main controller: Moore FSM sequencing the shared
// datapath, plus ALU operation decode.
module mc_control (
  input logic         clk,
  input logic         reset,
  mc_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] AOP_ADD = 2'b00;
  localparam logic [1:0] AOP_SUB = 2'b01;
  localparam logic [1:0] AOP_FN  = 2'b10;

  state_t     state_q;
  state_t     state_d;
  state_t     cur;
  logic       pcwrite;
  logic       branch;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic [1:0] aluop;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // While held in reset the outputs look like FETCH with enables gated.
  assign cur = reset ? state_q : FETCH;

  always_comb begin
    state_d      = FETCH;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    memwrite     = 1'b0;
    irwrite      = 1'b0;
    regwrite     = 1'b0;
    aluop        = AOP_ADD;
    bus.iord     = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regdst   = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcsrc    = 2'b00;
    case (cur)
      FETCH: begin
        irwrite     = 1'b1;
        pcwrite     = 1'b1;
        bus.alusrcb = 2'b01;
        state_d     = DECODE;
      end
      DECODE: begin
        bus.alusrcb = 2'b11;
        unique case (1'b1)
          (bus.op == OP_LW),
          (bus.op == OP_SW):   state_d = MEMADR;
          (bus.op == OP_RTYP): state_d = RTYPEEX;
          (bus.op == OP_BEQ):  state_d = BEQEX;
          (bus.op == OP_ADDI): state_d = ADDIEX;
          (bus.op == OP_J):    state_d = JEX;
          default:             state_d = FETCH;
        endcase
      end
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = (bus.op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        bus.iord = 1'b1;
        state_d  = MEMWB;
      end
      MEMWB: begin
        bus.memtoreg = 1'b1;
        regwrite     = 1'b1;
      end
      MEMWR: begin
        bus.iord = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        bus.alusrca = 1'b1;
        aluop       = AOP_FN;
        state_d     = RTYPEWB;
      end
      RTYPEWB: begin
        bus.regdst = 1'b1;
        regwrite   = 1'b1;
      end
      BEQEX: begin
        bus.alusrca = 1'b1;
        aluop       = AOP_SUB;
        bus.pcsrc   = 2'b01;
        branch      = 1'b1;
      end
      ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = ADDIWB;
      end
      ADDIWB: regwrite = 1'b1;
      JEX: begin
        bus.pcsrc = 2'b10;
        pcwrite   = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    bus.alucontrol = 3'b010;
    case (aluop)
      AOP_SUB: bus.alucontrol = 3'b110;
      AOP_FN: begin
        case (bus.funct)
          6'b100010: bus.alucontrol = 3'b110;
          6'b100100: bus.alucontrol = 3'b000;
          6'b100101: bus.alucontrol = 3'b001;
          6'b101010: bus.alucontrol = 3'b111;
          default:   bus.alucontrol = 3'b010;
        endcase
      end
      default: bus.alucontrol = 3'b010;
    endcase
  end

  assign bus.pcen     = reset & (pcwrite | (branch & bus.zero));
  assign bus.memwrite = reset & memwrite;
  assign bus.irwrite  = reset & irwrite;
  assign bus.regwrite = reset & regwrite;
  assign bus.state    = cur;

endmodule
